// File: rtl/keyboard_event_decoder.sv
// keyboard_event_decoder
//   Turns the raw PS/2 Set-2 byte stream into make/break key events.
//   Resolves F0 (break), E0 (extended) and E1 (pause) prefixes, tracks up to
//   MAX_KEYS held keys to filter typematic repeats, and queues events in a
//   FIFO_DEPTH-entry FIFO read out with a valid/ready handshake.
// Ports:
//   clk, reset          clock; synchronous active-low reset
//   byte_valid/byte_data received scan byte strobe and value
//   evt_valid/evt_ready FIFO head handshake
//   evt_code/ext/make   head event fields (0 while evt_valid=0)
//   held_count          number of valid held-key table entries
//   overflow            sticky: an event was dropped on a full FIFO
module keyboard_event_decoder #(
  parameter int unsigned MAX_KEYS      = 4,
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter bit          FILTER_REPEAT = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          byte_valid,
  input  logic [7:0]                    byte_data,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [7:0]                    evt_code,
  output logic                          evt_ext,
  output logic                          evt_make,
  output logic [$clog2(MAX_KEYS+1)-1:0] held_count,
  output logic                          overflow
);
  localparam int unsigned HCW = $clog2(MAX_KEYS + 1);
  localparam int unsigned PW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned KIW = (MAX_KEYS > 1) ? $clog2(MAX_KEYS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK, S_PAUSE} state_e;
  typedef struct packed {
    logic       ext;
    logic       make;
    logic [7:0] code;
  } evt_t;

  state_e     state_q, state_d;
  logic [2:0] skip_q, skip_d;
  logic       req, req_bypass, clr_all;
  evt_t       req_evt;

  // Prefix decoder: decides what (if anything) the current byte produces.
  always_comb begin
    state_d    = state_q;
    skip_d     = skip_q;
    req        = 1'b0;
    req_bypass = 1'b0;
    clr_all    = 1'b0;
    req_evt    = '{ext: 1'b0, make: 1'b1, code: byte_data};
    if (byte_valid) begin
      case (state_q)
        S_IDLE: begin
          case (byte_data)
            8'hE0: state_d = S_EXT;
            8'hF0: state_d = S_BRK;
            8'hE1: begin
              state_d = S_PAUSE;
              skip_d  = 3'd7;
            end
            8'hAA: clr_all = 1'b1;
            8'h00, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: ;
            default: req = 1'b1;
          endcase
        end
        S_EXT: begin
          case (byte_data)
            8'hF0: state_d = S_EXT_BRK;
            8'hE0: ;
            8'h12, 8'h59: state_d = S_IDLE;
            default: begin
              req         = 1'b1;
              req_evt.ext = 1'b1;
              state_d     = S_IDLE;
            end
          endcase
        end
        S_BRK: begin
          req          = 1'b1;
          req_evt.make = 1'b0;
          state_d      = S_IDLE;
        end
        S_EXT_BRK: begin
          state_d = S_IDLE;
          if (byte_data != 8'h12 && byte_data != 8'h59) begin
            req          = 1'b1;
            req_evt.ext  = 1'b1;
            req_evt.make = 1'b0;
          end
        end
        S_PAUSE: begin
          skip_d = skip_q - 3'd1;
          if (skip_q <= 3'd1) begin
            // Pause has no break code, so it never enters the held table
            // (it would otherwise stay held forever).
            req          = 1'b1;
            req_bypass   = 1'b1;
            req_evt.ext  = 1'b1;
            req_evt.code = 8'h77;
            skip_d       = 3'd0;
            state_d      = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Held-key table
  logic [MAX_KEYS-1:0] kv_q, kv_d;
  logic [MAX_KEYS-1:0] kx_q, kx_d;
  logic [7:0]          kc_q [MAX_KEYS];
  logic [7:0]          kc_d [MAX_KEYS];
  logic                hit, free_ok;
  logic [KIW-1:0]      hit_idx, free_idx;
  logic                push;

  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free_ok  = 1'b0;
    free_idx = '0;
    for (int unsigned i = 0; i < MAX_KEYS; i++) begin
      if (!hit && kv_q[i] && kx_q[i] == req_evt.ext && kc_q[i] == req_evt.code) begin
        hit     = 1'b1;
        hit_idx = KIW'(i);
      end
      if (!free_ok && !kv_q[i]) begin
        free_ok  = 1'b1;
        free_idx = KIW'(i);
      end
    end
  end

  always_comb begin
    kv_d = kv_q;
    kx_d = kx_q;
    kc_d = kc_q;
    push = 1'b0;
    if (clr_all) begin
      kv_d = '0;
    end else if (req) begin
      if (req_bypass) begin
        push = 1'b1;
      end else if (req_evt.make) begin
        if (!(hit && FILTER_REPEAT)) push = 1'b1;
        // A full table still emits the make; the key is just not recorded.
        if (!hit && free_ok) begin
          kv_d[free_idx] = 1'b1;
          kx_d[free_idx] = req_evt.ext;
          kc_d[free_idx] = req_evt.code;
        end
      end else begin
        push = 1'b1;
        if (hit) kv_d[hit_idx] = 1'b0;
      end
    end
  end

  always_comb begin
    held_count = '0;
    for (int unsigned i = 0; i < MAX_KEYS; i++) begin
      held_count = held_count + HCW'(kv_q[i]);
    end
  end

  // Event FIFO
  evt_t          mem [FIFO_DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          ovf_q;
  logic          full, pop, wr_en;

  assign full      = (cnt_q == CW'(FIFO_DEPTH));
  assign evt_valid = (cnt_q != '0);
  assign pop       = evt_valid && evt_ready;
  assign wr_en     = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_q] <= req_evt;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      skip_q  <= '0;
      kv_q    <= '0;
      kx_q    <= '0;
      for (int unsigned i = 0; i < MAX_KEYS; i++) kc_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      kv_q    <= kv_d;
      kx_q    <= kx_d;
      kc_q    <= kc_d;
      if (wr_en) wr_q <= wr_q + PW'(1);
      if (pop)   rd_q <= rd_q + PW'(1);
      case ({wr_en, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: ;
      endcase
      if (push && !wr_en) ovf_q <= 1'b1;
    end
  end

  assign evt_code = evt_valid ? mem[rd_q].code : '0;
  assign evt_ext  = evt_valid ? mem[rd_q].ext  : 1'b0;
  assign evt_make = evt_valid ? mem[rd_q].make : 1'b0;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_keyboard_event_decoder.sv
module tb_keyboard_event_decoder;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic       evt_ready = 1'b0;
  logic       evt_ready2 = 1'b0;

  logic       evt_valid, evt_ext, evt_make, overflow;
  logic [7:0] evt_code;
  logic [2:0] held_count;
  logic       evt_valid2, evt_ext2, evt_make2, overflow2;
  logic [7:0] evt_code2;
  logic [2:0] held_count2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  keyboard_event_decoder #(.MAX_KEYS(4), .FIFO_DEPTH(8), .FILTER_REPEAT(1'b1)) dut (
    .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
    .evt_ext(evt_ext), .evt_make(evt_make), .held_count(held_count),
    .overflow(overflow)
  );

  keyboard_event_decoder #(.MAX_KEYS(4), .FIFO_DEPTH(8), .FILTER_REPEAT(1'b0)) dut_nf (
    .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
    .evt_valid(evt_valid2), .evt_ready(evt_ready2), .evt_code(evt_code2),
    .evt_ext(evt_ext2), .evt_make(evt_make2), .held_count(held_count2),
    .overflow(overflow2)
  );

  // All tasks start and end just after a falling edge.
  task automatic send(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Returns {valid, ext, make, code} of the head and pops it if valid.
  task automatic pop_evt(output logic [10:0] o);
    o = {evt_valid, evt_ext, evt_make, evt_code};
    if (evt_valid) begin
      evt_ready = 1'b1;
      @(negedge clk);
      evt_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [13:0] obs;
    do_reset();
    obs = {evt_valid, evt_code, evt_ext, evt_make, held_count, overflow};
    checks++;
    if (obs !== 14'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h want %h", obs, 14'h0);
    end
  endtask

  task automatic test_press_release();
    logic [10:0] o;
    logic [10:0] peek;
    do_reset();
    send(8'h1C);
    checks++;
    if (held_count !== 3'd1) begin
      errors++;
      $display("FAIL press_held got %0d want 1", held_count);
    end
    peek = {evt_valid, evt_ext, evt_make, evt_code};
    checks++;
    if (peek !== {3'b101, 8'h1C}) begin
      errors++;
      $display("FAIL press_latency got %h want %h", peek, {3'b101, 8'h1C});
    end
    send(8'hF0);
    send(8'h1C);
    checks++;
    if (held_count !== 3'd0) begin
      errors++;
      $display("FAIL release_held got %0d want 0", held_count);
    end
    pop_evt(o);
    checks++;
    if (o !== {3'b101, 8'h1C}) begin
      errors++;
      $display("FAIL press_evt got %h want %h", o, {3'b101, 8'h1C});
    end
    pop_evt(o);
    checks++;
    if (o !== {3'b100, 8'h1C}) begin
      errors++;
      $display("FAIL release_evt got %h want %h", o, {3'b100, 8'h1C});
    end
    pop_evt(o);
    checks++;
    if (o !== 11'h0) begin
      errors++;
      $display("FAIL empty_zero got %h want %h", o, 11'h0);
    end
  endtask

  task automatic test_typematic();
    logic [10:0] o;
    int n;
    do_reset();
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
    pop_evt(o);
    checks++;
    if (o !== {3'b101, 8'h1C}) begin
      errors++;
      $display("FAIL typematic_make got %h want %h", o, {3'b101, 8'h1C});
    end
    pop_evt(o);
    checks++;
    if (o !== {3'b100, 8'h1C}) begin
      errors++;
      $display("FAIL typematic_break got %h want %h", o, {3'b100, 8'h1C});
    end
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL typematic_extra got valid=%b want 0", evt_valid);
    end
    n = 0;
    for (int k = 0; k < 10; k++) begin
      if (evt_valid2) begin
        n++;
        evt_ready2 = 1'b1;
        @(negedge clk);
        evt_ready2 = 1'b0;
      end
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL nofilter_count got %0d want 4", n);
    end
  endtask

  task automatic test_extended();
    logic [10:0] o;
    logic [3:0]  obs;
    do_reset();
    send(8'hE0); send(8'h75);
    checks++;
    if (held_count !== 3'd1) begin
      errors++;
      $display("FAIL ext_held got %0d want 1", held_count);
    end
    send(8'hE0); send(8'hF0); send(8'h75);
    pop_evt(o);
    checks++;
    if (o !== {3'b111, 8'h75}) begin
      errors++;
      $display("FAIL ext_make got %h want %h", o, {3'b111, 8'h75});
    end
    pop_evt(o);
    checks++;
    if (o !== {3'b110, 8'h75}) begin
      errors++;
      $display("FAIL ext_break got %h want %h", o, {3'b110, 8'h75});
    end
    send(8'hE0); send(8'h12);
    send(8'hE0); send(8'hF0); send(8'h59);
    obs = {evt_valid, held_count};
    checks++;
    if (obs !== 4'h0) begin
      errors++;
      $display("FAIL fake_shift got %h want %h", obs, 4'h0);
    end
    send(8'h1C);
    pop_evt(o);
    checks++;
    if (o !== {3'b101, 8'h1C}) begin
      errors++;
      $display("FAIL after_fake got %h want %h", o, {3'b101, 8'h1C});
    end
  endtask

  task automatic test_table_full();
    logic [10:0] o;
    logic [3:0]  obs;
    logic [7:0]  c [5] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
    do_reset();
    for (int i = 0; i < 5; i++) send(c[i]);
    checks++;
    if (held_count !== 3'd4) begin
      errors++;
      $display("FAIL full_held got %0d want 4", held_count);
    end
    for (int i = 0; i < 5; i++) begin
      pop_evt(o);
      checks++;
      if (o !== {3'b101, c[i]}) begin
        errors++;
        $display("FAIL full_evt%0d got %h want %h", i, o, {3'b101, c[i]});
      end
    end
    send(8'h2C);
    pop_evt(o);
    checks++;
    if (o !== {3'b101, 8'h2C}) begin
      errors++;
      $display("FAIL unrecorded_again got %h want %h", o, {3'b101, 8'h2C});
    end
    send(8'hF0); send(8'h15);
    pop_evt(o);
    obs = {evt_valid, held_count};
    checks++;
    if ({o, obs} !== {3'b100, 8'h15, 4'h3}) begin
      errors++;
      $display("FAIL free_entry got %h want %h", {o, obs}, {3'b100, 8'h15, 4'h3});
    end
    send(8'h2C);
    pop_evt(o);
    send(8'h2C);
    obs = {evt_valid, held_count};
    checks++;
    if ({o, obs} !== {3'b101, 8'h2C, 4'h4}) begin
      errors++;
      $display("FAIL reuse_filter got %h want %h", {o, obs}, {3'b101, 8'h2C, 4'h4});
    end
    send(8'hAA);
    obs = {evt_valid, held_count};
    checks++;
    if (obs !== 4'h0) begin
      errors++;
      $display("FAIL bat_clear got %h want %h", obs, 4'h0);
    end
  endtask

  task automatic test_pause();
    logic [10:0] o;
    logic [7:0]  seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    do_reset();
    for (int i = 0; i < 8; i++) send(seq[i]);
    pop_evt(o);
    checks++;
    if (o !== {3'b111, 8'h77}) begin
      errors++;
      $display("FAIL pause_evt got %h want %h", o, {3'b111, 8'h77});
    end
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL pause_single got valid=%b want 0", evt_valid);
    end
    send(8'h1C);
    pop_evt(o);
    checks++;
    if (o !== {3'b101, 8'h1C}) begin
      errors++;
      $display("FAIL after_pause got %h want %h", o, {3'b101, 8'h1C});
    end
  endtask

  task automatic test_overflow();
    logic [10:0] o;
    logic [11:0] head;
    logic [13:0] obs;
    logic [7:0]  c [9] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
    do_reset();
    for (int i = 0; i < 9; i++) send(c[i]);
    repeat (2) @(negedge clk);
    head = {overflow, evt_valid, evt_ext, evt_make, evt_code};
    checks++;
    if (head !== {4'b1101, 8'h15}) begin
      errors++;
      $display("FAIL overflow_set got %h want %h", head, {4'b1101, 8'h15});
    end
    for (int i = 0; i < 8; i++) begin
      pop_evt(o);
      checks++;
      if (o !== {3'b101, c[i]}) begin
        errors++;
        $display("FAIL drain%0d got %h want %h", i, o, {3'b101, c[i]});
      end
    end
    checks++;
    if ({evt_valid, overflow} !== 2'b01) begin
      errors++;
      $display("FAIL drained got %b want 01", {evt_valid, overflow});
    end
    // Break prefix, then reset with byte_valid/evt_ready also active.
    send(8'hF0);
    reset = 1'b0; byte_valid = 1'b1; byte_data = 8'h1C; evt_ready = 1'b1;
    @(negedge clk);
    reset = 1'b1; byte_valid = 1'b0; evt_ready = 1'b0;
    obs = {evt_valid, evt_code, evt_ext, evt_make, held_count, overflow};
    checks++;
    if (obs !== 14'h0) begin
      errors++;
      $display("FAIL reset_priority got %h want %h", obs, 14'h0);
    end
    send(8'h1C);
    pop_evt(o);
    checks++;
    if (o !== {3'b101, 8'h1C}) begin
      errors++;
      $display("FAIL reset_mid_seq got %h want %h", o, {3'b101, 8'h1C});
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] o;
    logic [7:0]  c [9] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
    do_reset();
    for (int i = 0; i < 8; i++) send(c[i]);
    // Push into a full FIFO while popping the head in the same cycle.
    byte_valid = 1'b1; byte_data = c[8]; evt_ready = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0; evt_ready = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_push_pop_ovf got %b want 0", overflow);
    end
    for (int i = 1; i < 9; i++) begin
      pop_evt(o);
      checks++;
      if (o !== {3'b101, c[i]}) begin
        errors++;
        $display("FAIL b2b%0d got %h want %h", i, o, {3'b101, c[i]});
      end
    end
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_empty got valid=%b want 0", evt_valid);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_press_release();
    test_typematic();
    test_extended();
    test_table_full();
    test_pause();
    test_overflow();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
